// File: rtl/operand_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_loader_pkg
//  Description : Shared definitions for the operand loader.
//                Holds the FSM state encoding, which is also driven onto the
//                state LEDs, and the default operand width.
//  Revision    : 1.0  initial release
// ============================================================================
package operand_loader_pkg;

    localparam int c_default_width = 4;

    // The encoding is visible on the board LEDs, so it is fixed explicitly.
    typedef enum logic [1:0] {
        S_LOAD_A = 2'b00,
        S_LOAD_B = 2'b01,
        S_ADD    = 2'b10,
        S_DONE   = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/operand_loader_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Turns a raw, asynchronous push-button into a single-cycle
//                pulse per press: 2-flop synchroniser, optional debounce
//                filter, then rising-edge detect.
//                Optional feature macro: DEBOUNCE_EN (adds the filter).
//  Ports       : clk     - system clock
//                rst_n   - synchronous active-low reset
//                i_btn   - raw button level
//                o_pulse - one-cycle pulse per press (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module btn_conditioner #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic [1:0] r_sync;
    // Tracks how far real post-reset samples have travelled down the
    // synchroniser; r_fill[1] means r_sync[1] holds a genuine sample.
    logic [1:0] r_fill;
    logic       r_prev;
    logic       r_pulse;
    logic       w_level;
    logic       w_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
            r_fill <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_fill <= {r_fill[0], 1'b1};
        end
    end

`ifdef DEBOUNCE_EN
    localparam int c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_filt;
    logic               r_primed;

    // The filter is seeded from the first genuine sample instead of from 0,
    // so a button held through reset does not look like a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_filt   <= 1'b0;
            r_primed <= 1'b0;
        end else if (!r_primed) begin
            if (r_fill[1]) begin
                r_filt   <= r_sync[1];
                r_primed <= 1'b1;
            end
        end else if (r_sync[1] != r_filt) begin
            if (r_cnt == c_cnt_w'(DB_CYCLES - 1)) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_level = r_filt;
    assign w_ready = r_primed;
`else
    assign w_level = r_sync[1];
    assign w_ready = r_fill[1];
`endif

    // r_prev is held high until the level feeding it is genuine; the first
    // real level therefore can never register as a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev  <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= w_ready ? w_level : 1'b1;
            r_pulse <= w_ready & w_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : operand_loader
//  Description : Captures two operands from switches with a LOAD button,
//                presents them to an external combinational adder and latches
//                {carry,sum}. A CLR button aborts/restarts a transaction.
//                Optional feature macro: DEBOUNCE_EN (button debounce).
//  Ports       : clk, rst_n           - clock, synchronous active-low reset
//                sw                   - switch value, sampled on a load pulse
//                btn_load, btn_clr    - raw asynchronous buttons
//                a, b                 - operands to the adder
//                opnd_valid           - a/b meaningful (S_ADD, S_DONE)
//                sum_in, carry_in     - adder result
//                result, result_valid - latched {carry_in,sum_in}
//                state_led            - current state encoding
//  Revision    : 1.0  initial release
// ============================================================================
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int DB_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             opnd_valid,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             carry_in,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic [1:0]       state_led
);

    logic w_ld_p;
    logic w_clr_p;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_result;
    logic             r_opnd_valid;
    logic             r_result_valid;

    btn_conditioner #(
        .DB_CYCLES (DB_CYCLES)
    ) u_ld_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_load),
        .o_pulse (w_ld_p)
    );

    btn_conditioner #(
        .DB_CYCLES (DB_CYCLES)
    ) u_clr_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_clr),
        .o_pulse (w_clr_p)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_LOAD_A;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_opnd_valid   <= 1'b0;
            r_result_valid <= 1'b0;
        end else if (w_clr_p) begin
            // CLR wins over a simultaneous LOAD in every state.
            r_state        <= S_LOAD_A;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_opnd_valid   <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD_A: begin
                    if (w_ld_p) begin
                        r_a     <= sw;
                        r_state <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (w_ld_p) begin
                        r_b          <= sw;
                        r_opnd_valid <= 1'b1;
                        r_state      <= S_ADD;
                    end
                end
                S_ADD: begin
                    // a/b have been stable for a full cycle, so the adder
                    // output is settled; load pulses here are dropped.
                    r_result       <= {carry_in, sum_in};
                    r_result_valid <= 1'b1;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    if (w_ld_p) begin
                        // New transaction: b is kept until reloaded.
                        r_a            <= sw;
                        r_result_valid <= 1'b0;
                        r_opnd_valid   <= 1'b0;
                        r_state        <= S_LOAD_B;
                    end
                end
                default: begin
                    r_state <= S_LOAD_A;
                end
            endcase
        end
    end

    assign a            = r_a;
    assign b            = r_b;
    assign result       = r_result;
    assign opnd_valid   = r_opnd_valid;
    assign result_valid = r_result_valid;
    assign state_led    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_loader
//  Description : Self-checking bench for operand_loader. A behavioural adder
//                drives sum_in/carry_in; a queue-based reference model of the
//                button path and transaction rules predicts every output.
//                Honours DEBOUNCE_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_loader;

    localparam int WIDTH = 4;
    localparam int DB    = 4;
`ifdef DEBOUNCE_EN
    localparam bit DBEN = 1'b1;
`else
    localparam bit DBEN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw;
    logic             btn_load;
    logic             btn_clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             opnd_valid;
    logic [WIDTH-1:0] sum_in;
    logic             carry_in;
    logic [WIDTH:0]   result;
    logic             result_valid;
    logic [1:0]       state_led;

    always #5 clk = ~clk;

    // Behavioural four-bit adder beside the loader.
    assign {carry_in, sum_in} = {1'b0, a} + {1'b0, b};

    operand_loader #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .btn_load     (btn_load),
        .btn_clr      (btn_clr),
        .a            (a),
        .b            (b),
        .opnd_valid   (opnd_valid),
        .sum_in       (sum_in),
        .carry_in     (carry_in),
        .result       (result),
        .result_valid (result_valid),
        .state_led    (state_led)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Raw button samples since reset are kept in queues;
    // a press is seen by the transaction logic 3 samples after the raw
    // rise (plus the stability window when debouncing).
    // ------------------------------------------------------------------
    bit       hl[$];
    bit       hc[$];
    bit       fl[$];
    bit       fc[$];
    bit       fvl, fvc;
    int       cvl, cvc;
    int       ms;
    bit [3:0] ma, mb;
    bit [4:0] mr;
    bit       mrv;

    function automatic bit filt_step(input bit x, input bit first, inout bit f, inout int c);
        if (first) begin
            f = x;
            c = 0;
        end else if (x != f) begin
            c++;
            if (c == DB) begin
                f = x;
                c = 0;
            end
        end else begin
            c = 0;
        end
        return f;
    endfunction

    always @(posedge clk) begin
        int n;
        bit ldp, clrp;
        if (!rst_n) begin
            hl.delete(); hc.delete(); fl.delete(); fc.delete();
            ms = 0; ma = 0; mb = 0; mr = 0; mrv = 0;
        end else begin
            n = hl.size();
            if (DBEN) begin
                ldp  = (n >= 5) && fl[n-4] && !fl[n-5];
                clrp = (n >= 5) && fc[n-4] && !fc[n-5];
            end else begin
                ldp  = (n >= 4) && hl[n-3] && !hl[n-4];
                clrp = (n >= 4) && hc[n-3] && !hc[n-4];
            end
            fl.push_back(filt_step(btn_load, n == 0, fvl, cvl));
            fc.push_back(filt_step(btn_clr,  n == 0, fvc, cvc));
            hl.push_back(btn_load);
            hc.push_back(btn_clr);

            if (clrp) begin
                ms = 0; ma = 0; mb = 0; mr = 0; mrv = 0;
            end else begin
                case (ms)
                    0: if (ldp) begin ma = sw; ms = 1; end
                    1: if (ldp) begin mb = sw; ms = 2; end
                    2: begin mr = {1'b0, ma} + {1'b0, mb}; mrv = 1; ms = 3; end
                    default: if (ldp) begin ma = sw; mrv = 0; ms = 1; end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("state_led",    state_led,    ms);
        check("a",            a,            ma);
        check("b",            b,            mb);
        check("result",       result,       mr);
        check("result_valid", result_valid, mrv);
        check("opnd_valid",   opnd_valid,   ms >= 2);
    endtask

    task automatic press(input bit ld, input bit cl, input int hold, input int gap, input bit rnd_sw);
        btn_load = ld;
        btn_clr  = cl;
        for (int i = 0; i < hold; i++) begin
            if (rnd_sw) sw = 4'($urandom);
            tick();
        end
        btn_load = 1'b0;
        btn_clr  = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (rnd_sw) sw = 4'($urandom);
            tick();
        end
    endtask

    initial begin
        int changes, first_chg;
        logic [1:0] prev_led;

        rst_n = 1'b0; sw = '0; btn_load = 1'b1; btn_clr = 1'b1;

        // 1: reset 3 cycles with buttons held, no pulse on release.
        repeat (3) tick();
        check("rst_led", state_led, 2'b00);
        check("rst_res", result, 5'h00);
        rst_n = 1'b1;
        repeat (12) tick();
        check("held_led", state_led, 2'b00);
        check("held_a", a, 4'h0);
        btn_load = 1'b0; btn_clr = 1'b0;
        repeat (12) tick();
        check("rel_led", state_led, 2'b00);

        // 2: 3 + 5.
        sw = 4'h3; press(1, 0, 8, 10, 0);
        sw = 4'h5; press(1, 0, 8, 10, 0);
        check("t2_a", a, 4'h3);
        check("t2_b", b, 4'h5);
        check("t2_ov", opnd_valid, 1'b1);
        check("t2_res", result, 5'h08);
        check("t2_rv", result_valid, 1'b1);
        check("t2_led", state_led, 2'b11);

        // 3: F + 1 carries, then a new A.
        sw = 4'hF; press(1, 0, 8, 10, 0);
        sw = 4'h1; press(1, 0, 8, 10, 0);
        check("t3_res", result, 5'h10);
        sw = 4'h2; press(1, 0, 8, 10, 0);
        check("t3_a", a, 4'h2);
        check("t3_rv", result_valid, 1'b0);
        check("t3_led", state_led, 2'b01);

        // 4: long hold gives a single capture.
        press(0, 1, 8, 10, 0);
        sw = 4'h7; press(1, 0, 20, 10, 0);
        check("t4_led", state_led, 2'b01);
        check("t4_a", a, 4'h7);

        // 5: LOAD and CLR together in S_LOAD_B.
        sw = 4'hC; press(1, 1, 8, 10, 0);
        check("t5_led", state_led, 2'b00);
        check("t5_a", a, 4'h0);
        check("t5_b", b, 4'h0);
        check("t5_res", result, 5'h00);

        // 6: bouncy LOAD, then steady high.
        sw = 4'h9; changes = 0; first_chg = -1; prev_led = state_led;
        for (int i = 0; i < 30; i++) begin
            btn_load = (i >= 10) ? 1'b1 : (((i / 2) % 2) == 0);
            tick();
            if (state_led !== prev_led) begin
                changes++;
                if (first_chg < 0) first_chg = i;
            end
            prev_led = state_led;
        end
        btn_load = 1'b0;
        repeat (12) tick();
        check("t6_changes", changes,   DBEN ? 1 : 4);
        check("t6_latency", first_chg, DBEN ? 8 + 3 + DB : 3);

        // 7: reset mid-transaction while LOAD is held.
        press(0, 1, 8, 10, 0);
        sw = 4'h4; press(1, 0, 8, 10, 0);
        btn_load = 1'b1;
        repeat (8) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("t7_led", state_led, 2'b00);
        check("t7_b", b, 4'h0);
        btn_load = 1'b0;
        repeat (12) tick();

        // Randomised traffic against the model.
        for (int it = 0; it < 150; it++) begin
            int r;
            r  = $urandom_range(0, 19);
            sw = 4'($urandom);
            if (r == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                rst_n = 1'b1;
            end else if (r < 3) begin
                press(0, 1, $urandom_range(1, 10), $urandom_range(1, 10), 1);
            end else if (r == 4) begin
                for (int k = 0; k < 8; k++) begin
                    btn_load = 1'($urandom);
                    tick();
                end
                btn_load = 1'b0;
                repeat (6) tick();
            end else begin
                press(1, r == 3, $urandom_range(1, 10), $urandom_range(1, 10), r > 12);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
